// File: rtl/disp_pkg.sv
// Shared definitions for the 6-digit multiplexed display scanner.
//   IDX_*     : digit positions, 0 = rightmost (seconds ones) .. 5 = hours tens
//   SEG_*     : active-high {g,f,e,d,c,b,a} segment patterns
//   seg7_decode: BCD digit -> active-high segment pattern, non-BCD codes -> dash
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [2:0] IDX_SEC_ONES = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS = 3'd3;
    localparam logic [2:0] IDX_HR_ONES  = 3'd4;
    localparam logic [2:0] IDX_HR_TENS  = 3'd5;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
//   bcd : 4-bit digit code (10..15 shown as a dash)
//   seg : active-high {g,f,e,d,c,b,a}
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_decode(bcd);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 6-digit 7-segment driver for the hh.mm.ss counter chain.
//   clk, reset         : system clock, synchronous active-high reset
//   hr/min/sec_tens/ones: BCD digits, captured once per frame
//   blank_lead         : suppress hours-tens when the captured value is 0
//   blink_en/blink_mask: blank selected digits during the off half of the blink
//   seg                : {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp                 : separator dot, polarity per SEG_ACTIVE_LOW
//   dig_sel            : one-hot digit enable, polarity per DIG_ACTIVE_LOW
module bcd_display_scanner
    import disp_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       blank_lead,
    input  logic       blink_en,
    input  logic [5:0] blink_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel
);

    localparam int unsigned DWELL      = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BLINK_HALF = SCAN_HZ / 2;
    localparam int unsigned BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_K    = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_HALF > 0) ? BLINK_HALF - 1 : 0);

    localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_IDLE  = (SEG_ACTIVE_LOW != 0);
    localparam logic [5:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [BW-1:0] bcnt, bcnt_next;
    logic          phase, phase_next;
    logic          tick;

    logic [3:0]    shadow [NUM_DIGITS];
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;

    logic [5:0]    onehot;
    logic          dead;
    logic          blanked;
    logic [6:0]    seg_on;
    logic [5:0]    dig_on;
    logic          dp_on;
    logic [6:0]    seg_next;
    logic [5:0]    dig_next;
    logic          dp_next;

    // Scan state register plus frame snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= IDX_SEC_ONES;
            bcnt  <= '0;
            phase <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            bcnt  <= bcnt_next;
            phase <= phase_next;
            // Capture on the last tick of a frame so all six digits come from one instant
            if (tick && idx == IDX_HR_TENS) begin
                shadow[IDX_SEC_ONES] <= sec_ones;
                shadow[IDX_SEC_TENS] <= sec_tens;
                shadow[IDX_MIN_ONES] <= min_ones;
                shadow[IDX_MIN_TENS] <= min_tens;
                shadow[IDX_HR_ONES]  <= hr_ones;
                shadow[IDX_HR_TENS]  <= hr_tens;
            end
        end
    end

    // Prescaler, digit index and blink phase advance
    always_comb begin
        tick       = (cnt == CNT_LAST);
        cnt_next   = tick ? '0 : cnt + 1'b1;
        idx_next   = idx;
        bcnt_next  = bcnt;
        phase_next = phase;
        if (tick) begin
            idx_next = (idx == IDX_HR_TENS) ? IDX_SEC_ONES : idx + 3'd1;
            if (bcnt == BLINK_LAST) begin
                bcnt_next  = '0;
                phase_next = ~phase;
            end else begin
                bcnt_next = bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        case (idx)
            IDX_SEC_ONES: cur_digit = shadow[IDX_SEC_ONES];
            IDX_SEC_TENS: cur_digit = shadow[IDX_SEC_TENS];
            IDX_MIN_ONES: cur_digit = shadow[IDX_MIN_ONES];
            IDX_MIN_TENS: cur_digit = shadow[IDX_MIN_TENS];
            IDX_HR_ONES:  cur_digit = shadow[IDX_HR_ONES];
            IDX_HR_TENS:  cur_digit = shadow[IDX_HR_TENS];
            default:      cur_digit = '0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Next output values; blink and leading-zero controls are taken live
    always_comb begin
        onehot  = 6'b000001 << idx;
        dead    = (cnt < BLANK_K);
        blanked = (blink_en && (|(blink_mask & onehot)) && phase)
               || (blank_lead && idx == IDX_HR_TENS && shadow[IDX_HR_TENS] == 4'd0);
        seg_on  = (dead || blanked) ? SEG_OFF : dec_seg;
        dig_on  = dead ? '0 : onehot;
        dp_on   = !dead && !blanked && !phase
               && (idx == IDX_MIN_ONES || idx == IDX_HR_ONES);
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_next  = (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
        dig_next = (DIG_ACTIVE_LOW != 0) ? ~dig_on : dig_on;
    end

    // Registered pins, one clock behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            seg     <= SEG_IDLE;
            dp      <= DP_IDLE;
            dig_sel <= DIG_IDLE;
        end else begin
            seg     <= seg_next;
            dp      <= dp_next;
            dig_sel <= dig_next;
        end
    end

endmodule
